// File: rtl/pot_scan_avg_if.sv
// A2D handshake bundle: the scanner (master) requests conversions on a channel,
// the converter (slave) returns a one-cycle done strobe with the result.
interface pot_scan_avg_if #(
  parameter int RES_W = 12
);
  logic             strt_cnv;
  logic [2:0]       chnnl;
  logic             cnv_cmplt;
  logic [RES_W-1:0] res;

  modport master (output strt_cnv, chnnl, input cnv_cmplt, res);
  modport slave  (input strt_cnv, chnnl, output cnv_cmplt, res);
endinterface

// File: rtl/pot_scan_avg.sv
// Round-robin potentiometer scanner: converts each mapped A2D channel in turn,
// averages 2^AVG_SHIFT passes per slot and publishes values with hysteresis.
module pot_scan_avg #(
  parameter int                    NUM_CH    = 6,
  parameter int                    RES_W     = 12,
  parameter int                    AVG_SHIFT = 2,
  parameter int                    HYST      = 4,
  parameter logic [NUM_CH*3-1:0]   CH_MAP    = {3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
  parameter logic [RES_W-1:0]      RST_VAL   = 'h800
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  pot_scan_avg_if.master            a2d,
  output logic [NUM_CH*RES_W-1:0]   pot_val,
  output logic [NUM_CH-1:0]         chg,
  output logic                      upd
);

  localparam int ACC_W  = RES_W + AVG_SHIFT;
  localparam int PASS_W = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;
  localparam logic [PASS_W-1:0] PASS_MAX = PASS_W'((1 << AVG_SHIFT) - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [2:0]              r_slot;
  logic [PASS_W-1:0]       r_pass;
  logic [ACC_W-1:0]        r_acc  [NUM_CH];
  logic [RES_W-1:0]        r_pot  [NUM_CH];
  logic [NUM_CH-1:0]       r_chg;
  logic                    r_upd;
  logic                    r_first;

  logic                    w_cmplt;
  logic                    w_last;
  logic                    w_round_end;
  logic [ACC_W-1:0]        w_sum  [NUM_CH];
  logic [RES_W-1:0]        w_avg  [NUM_CH];
  logic [NUM_CH-1:0]       w_big;
  logic [2:0]              w_chnnl;

  function automatic logic [RES_W-1:0] abs_diff(input logic [RES_W-1:0] a,
                                                input logic [RES_W-1:0] b);
    logic signed [RES_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? RES_W'(-d) : RES_W'(d);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // A conversion in flight always completes; en only decides where WAIT goes next.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (en) w_next = START;
      START:   w_next = WAIT;
      WAIT:    if (a2d.cnv_cmplt) w_next = en ? START : IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_cmplt     = (r_state == WAIT) && a2d.cnv_cmplt;
  assign w_last      = (r_slot == 3'(NUM_CH - 1));
  assign w_round_end = w_cmplt && w_last && (r_pass == PASS_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot <= '0;
      r_pass <= '0;
    end else if (w_cmplt) begin
      if (w_last) begin
        r_slot <= '0;
        r_pass <= (r_pass == PASS_MAX) ? '0 : r_pass + 1'b1;
      end else begin
        r_slot <= r_slot + 3'd1;
      end
    end
  end

  // The last slot's final sample is still on res at the round-end edge, so fold it in here.
  always_comb begin
    for (int s = 0; s < NUM_CH; s++) begin
      w_sum[s] = r_acc[s] + ((s == NUM_CH - 1) ? ACC_W'(a2d.res) : ACC_W'(0));
      w_avg[s] = RES_W'(w_sum[s] >> AVG_SHIFT);
      w_big[s] = (abs_diff(w_avg[s], r_pot[s]) > RES_W'(HYST)) || r_first;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_CH; s++) r_acc[s] <= '0;
    end else begin
      for (int s = 0; s < NUM_CH; s++) begin
        if (w_round_end)
          r_acc[s] <= '0;
        else if (w_cmplt && (r_slot == 3'(s)))
          r_acc[s] <= r_acc[s] + ACC_W'(a2d.res);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_CH; s++) r_pot[s] <= RST_VAL;
      r_chg   <= '0;
      r_upd   <= 1'b0;
      r_first <= 1'b1;
    end else begin
      r_upd <= w_round_end;
      if (w_round_end) begin
        r_first <= 1'b0;
        r_chg   <= w_big;
        for (int s = 0; s < NUM_CH; s++)
          if (w_big[s]) r_pot[s] <= w_avg[s];
      end
    end
  end

  always_comb begin
    w_chnnl = '0;
    for (int s = 0; s < NUM_CH; s++)
      if (r_slot == 3'(s)) w_chnnl = CH_MAP[3*s +: 3];
  end

  always_comb begin
    pot_val = '0;
    for (int s = 0; s < NUM_CH; s++) pot_val[RES_W*s +: RES_W] = r_pot[s];
  end

  assign a2d.strt_cnv = (r_state == START);
  assign a2d.chnnl    = w_chnnl;
  assign chg          = r_chg;
  assign upd          = r_upd;

endmodule

// File: tb/tb_pot_scan_avg.sv
// Directed bench for pot_scan_avg: default 6-slot build plus a 1-slot,
// no-averaging, zero-hysteresis build, each driven by a scripted A2D responder.
module tb_pot_scan_avg;

  logic clk = 1'b0;
  logic rst;
  logic en0, en1;
  always #5 clk = ~clk;

  pot_scan_avg_if #(.RES_W(12)) a0 ();
  pot_scan_avg_if #(.RES_W(12)) a1 ();

  logic [71:0] pv0;
  logic [5:0]  chg0;
  logic        upd0;
  logic [11:0] pv1;
  logic [0:0]  chg1;
  logic        upd1;

  pot_scan_avg u0 (
    .clk(clk), .rst(rst), .en(en0), .a2d(a0.master),
    .pot_val(pv0), .chg(chg0), .upd(upd0)
  );

  pot_scan_avg #(.NUM_CH(1), .AVG_SHIFT(0), .HYST(0), .CH_MAP(3'd5)) u1 (
    .clk(clk), .rst(rst), .en(en1), .a2d(a1.master),
    .pot_val(pv1), .chg(chg1), .upd(upd1)
  );

  int checks = 0;
  int errors = 0;
  logic upd_nxt0;
  logic [2:0] chmap [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};

  typedef struct packed {
    logic [5:0][3:0][11:0] smp;
    logic [5:0][11:0]      pot;
    logic [5:0]            chg;
  } rnd_t;
  rnd_t rounds [5];

  typedef struct packed {
    logic [11:0] res;
    logic        chg;
  } one_t;
  one_t ones [6];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fill_slot(input int r, input int s, input logic [11:0] v);
    for (int p = 0; p < 4; p++) rounds[r].smp[s][p] = v;
  endtask

  task automatic conv0(input logic [11:0] v, input logic [2:0] ch, input bit drop);
    int n = 0;
    while (a0.strt_cnv !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("strt_cnv_seen", a0.strt_cnv, 1);
    chk("chnnl", a0.chnnl, ch);
    @(negedge clk);
    upd_nxt0 = upd0;
    chk("strt_one_cycle", a0.strt_cnv, 0);
    if (drop) en0 = 1'b0;
    @(negedge clk);
    chk("chnnl_hold", a0.chnnl, ch);
    a0.cnv_cmplt = 1'b1;
    a0.res       = v;
    @(negedge clk);
    a0.cnv_cmplt = 1'b0;
  endtask

  task automatic run_round(input int r, input int drop_idx, input bit after_round);
    int idx;
    logic seen;
    for (int p = 0; p < 4; p++) begin
      for (int s = 0; s < 6; s++) begin
        idx = p * 6 + s;
        if (idx == 23) chk("upd_early", upd0, 0);
        conv0(rounds[r].smp[s][p], chmap[s], idx == drop_idx);
        if (idx == 0 && after_round) chk("upd_width", upd_nxt0, 0);
        if (idx == drop_idx) begin
          seen = 1'b0;
          repeat (8) begin @(negedge clk); if (a0.strt_cnv) seen = 1'b1; end
          chk("idle_no_strt", seen, 0);
          en0 = 1'b1;
        end
      end
    end
    chk("upd_pulse", upd0, 1);
    for (int s = 0; s < 6; s++)
      chk($sformatf("pot_val_r%0d_s%0d", r, s), pv0[12*s +: 12], rounds[r].pot[s]);
    chk($sformatf("chg_r%0d", r), chg0, rounds[r].chg);
  endtask

  task automatic conv1(input logic [11:0] v);
    int n = 0;
    while (a1.strt_cnv !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("n1_strt_seen", a1.strt_cnv, 1);
    chk("n1_chnnl", a1.chnnl, 5);
    @(negedge clk);
    @(negedge clk);
    a1.cnv_cmplt = 1'b1;
    a1.res       = v;
    @(negedge clk);
    a1.cnv_cmplt = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; en0 = 1'b0; en1 = 1'b0;
    a0.cnv_cmplt = 1'b0; a0.res = '0;
    a1.cnv_cmplt = 1'b0; a1.res = '0;

    // Round 0: flat 0x400, first round flags every slot.
    for (int s = 0; s < 6; s++) fill_slot(0, s, 12'h400);
    rounds[0].pot = {6{12'h400}};
    rounds[0].chg = 6'b111111;
    // Round 1: hysteresis below/at threshold, truncated means.
    for (int s = 0; s < 6; s++) fill_slot(1, s, 12'h400);
    fill_slot(1, 0, 12'h403);
    fill_slot(1, 1, 12'h404);
    for (int p = 0; p < 4; p++) rounds[1].smp[2][p] = 12'h100 + 12'(p);
    rounds[1].smp[4] = {12'h503, 12'h500, 12'h500, 12'h500};
    rounds[1].pot = {12'h400, 12'h500, 12'h400, 12'h101, 12'h400, 12'h400};
    rounds[1].chg = 6'b010100;
    // Round 2: just over threshold both up and down.
    for (int s = 0; s < 6; s++) fill_slot(2, s, 12'h400);
    fill_slot(2, 0, 12'h405);
    fill_slot(2, 1, 12'h404);
    fill_slot(2, 2, 12'h101);
    fill_slot(2, 4, 12'h500);
    fill_slot(2, 5, 12'h3FB);
    rounds[2].pot = {12'h3FB, 12'h500, 12'h400, 12'h101, 12'h400, 12'h405};
    rounds[2].chg = 6'b100001;
    // Round 3: en dropped mid-round; only slot 3 moves.
    for (int s = 0; s < 6; s++) fill_slot(3, s, rounds[2].pot[s]);
    fill_slot(3, 3, 12'h408);
    rounds[3].pot = {12'h3FB, 12'h500, 12'h408, 12'h101, 12'h400, 12'h405};
    rounds[3].chg = 6'b001000;
    // Round 4: first full round after a mid-conversion reset.
    for (int s = 0; s < 6; s++) fill_slot(4, s, 12'h200);
    rounds[4].pot = {6{12'h200}};
    rounds[4].chg = 6'b111111;

    ones[0] = '{12'h123, 1'b1};
    ones[1] = '{12'h123, 1'b0};
    ones[2] = '{12'h124, 1'b1};
    ones[3] = '{12'hFFF, 1'b1};
    ones[4] = '{12'h000, 1'b1};
    ones[5] = '{12'h000, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_pot_val", pv0, {6{12'h800}});
    chk("rst_chg", chg0, 0);
    chk("rst_upd", upd0, 0);
    chk("rst_strt", a0.strt_cnv, 0);
    chk("rst_chnnl", a0.chnnl, 0);
    chk("rst_n1_pot_val", pv1, 12'h800);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_without_en", a0.strt_cnv, 0);
    a0.cnv_cmplt = 1'b1; a0.res = 12'hFFF;
    @(negedge clk);
    a0.cnv_cmplt = 1'b0;
    en0 = 1'b1;

    run_round(0, -1, 1'b0);
    run_round(1, -1, 1'b1);
    run_round(2, -1, 1'b1);
    run_round(3, 3, 1'b1);

    // Reset while waiting on slot 4 of pass 2.
    for (int i = 0; i < 16; i++) conv0(12'h300, chmap[i % 6], 1'b0);
    n = 0;
    while (a0.strt_cnv !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("mid_rst_chnnl", a0.chnnl, 4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_pot_val", pv0, {6{12'h800}});
    chk("mid_rst_chg", chg0, 0);
    chk("mid_rst_upd", upd0, 0);
    chk("mid_rst_strt", a0.strt_cnv, 0);
    @(negedge clk);
    en0 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    a0.cnv_cmplt = 1'b1; a0.res = 12'hFFF;
    @(negedge clk);
    a0.cnv_cmplt = 1'b0;
    chk("post_rst_idle", a0.strt_cnv, 0);
    en0 = 1'b1;
    run_round(4, -1, 1'b0);

    // Single slot, no averaging, zero hysteresis.
    en1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      conv1(ones[i].res);
      chk($sformatf("n1_upd_%0d", i), upd1, 1);
      chk($sformatf("n1_pot_val_%0d", i), pv1, ones[i].res);
      chk($sformatf("n1_chg_%0d", i), chg1, ones[i].chg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
